// File: rtl/riscv32_wb_port_arbiter_pkg.sv
// Shared constants for the writeback-port arbiter and its grant sub-module.
// Grant ids identify which requester produced a register-file write.
package riscv32_wb_port_arbiter_pkg;

    localparam int unsigned RV_XLEN       = 32;
    localparam int unsigned RV_REG_ADDR_W = 5;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/riscv32_rr_arb2.sv
// Two-input round-robin / fixed-priority grant with last-grant memory.
// Latency: grant is combinational from valids; backpressure: loser's ready stays low.
module riscv32_rr_arb2
    import riscv32_wb_port_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req0_vld,
    input  logic i_req1_vld,
    output logic o_gnt_vld,
    output logic o_gnt_id,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_last_gnt;
    logic w_gnt_vld;
    logic w_gnt_id;

    always_comb begin
        w_gnt_vld = i_req0_vld | i_req1_vld;
        w_gnt_id  = REQ_ALU;
        if (i_req0_vld && i_req1_vld) begin
            // On a tie, round-robin hands the port to whoever did not win last.
            w_gnt_id = RR_EN ? ~r_last_gnt : REQ_ALU;
        end else if (i_req1_vld) begin
            w_gnt_id = REQ_LSU;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_gnt <= REQ_LSU;
        end else if (w_gnt_vld) begin
            r_last_gnt <= w_gnt_id;
        end
    end

    assign o_gnt_vld = w_gnt_vld;
    assign o_gnt_id  = w_gnt_id;
    assign o_gnt0    = w_gnt_vld && (w_gnt_id == REQ_ALU);
    assign o_gnt1    = w_gnt_vld && (w_gnt_id == REQ_LSU);

endmodule

// File: rtl/riscv32_wb_port_arbiter.sv
// Shares the register-file write port between ALU (req0) and load/CSR (req1) writeback.
// Latency: 1 cycle handshake-to-write; backpressure: none downstream, loser of a tie waits.
module riscv32_wb_port_arbiter
    import riscv32_wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RV_XLEN,
    parameter int unsigned ADDR_W = RV_REG_ADDR_W,
    parameter bit          RR_EN  = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic              req0_valid_in,
    input  logic [ADDR_W-1:0] req0_rd_addr_in,
    input  logic [DATA_W-1:0] req0_data_in,
    output logic              req0_ready_out,
    input  logic              req1_valid_in,
    input  logic [ADDR_W-1:0] req1_rd_addr_in,
    input  logic [DATA_W-1:0] req1_data_in,
    output logic              req1_ready_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [DATA_W-1:0] rd_out,
    output logic              grant_id_out,
    output logic [CNT_W-1:0]  stall_cnt_out
);

    logic              w_gnt_vld;
    logic              w_gnt_id;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_data;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_gnt_id;
    logic [CNT_W-1:0]  r_stall_cnt;

    riscv32_rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .i_clk      (ms_riscv32_mp_clk_in),
        .i_rst      (ms_riscv32_mp_rst_in),
        .i_req0_vld (req0_valid_in),
        .i_req1_vld (req1_valid_in),
        .o_gnt_vld  (w_gnt_vld),
        .o_gnt_id   (w_gnt_id),
        .o_gnt0     (req0_ready_out),
        .o_gnt1     (req1_ready_out)
    );

    assign w_gnt_addr = (w_gnt_id == REQ_LSU) ? req1_rd_addr_in : req0_rd_addr_in;
    assign w_gnt_data = (w_gnt_id == REQ_LSU) ? req1_data_in    : req0_data_in;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_wr_en   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_gnt_id  <= REQ_ALU;
        end else if (w_gnt_vld) begin
            // x0 still handshakes so the requester retires it, but never reaches the file.
            r_wr_en   <= |w_gnt_addr;
            r_rd_addr <= w_gnt_addr;
            r_rd_data <= w_gnt_data;
            r_gnt_id  <= w_gnt_id;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_stall_cnt <= '0;
        end else if (req0_valid_in && req1_valid_in && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign wr_en_out     = r_wr_en;
    assign rd_addr_out   = r_rd_addr;
    assign rd_out        = r_rd_data;
    assign grant_id_out  = r_gnt_id;
    assign stall_cnt_out = r_stall_cnt;

endmodule

// File: tb/tb_riscv32_wb_port_arbiter.sv
// Bench: a round-robin and a fixed-priority instance driven by the same directed vectors,
// checked every cycle against a behavioural model plus literal expectations.
module tb_riscv32_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;

    logic        rr_rdy0, rr_rdy1, rr_wr, rr_id;
    logic [4:0]  rr_addr;
    logic [31:0] rr_data;
    logic [15:0] rr_stall;

    logic        fp_rdy0, fp_rdy1, fp_wr, fp_id;
    logic [4:0]  fp_addr;
    logic [31:0] fp_data;
    logic [2:0]  fp_stall;

    int n_tests = 0;
    int n_fail  = 0;

    riscv32_wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_EN(1'b1), .CNT_W(16)) u_rr (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .req0_valid_in        (v0),
        .req0_rd_addr_in      (a0),
        .req0_data_in         (d0),
        .req0_ready_out       (rr_rdy0),
        .req1_valid_in        (v1),
        .req1_rd_addr_in      (a1),
        .req1_data_in         (d1),
        .req1_ready_out       (rr_rdy1),
        .wr_en_out            (rr_wr),
        .rd_addr_out          (rr_addr),
        .rd_out               (rr_data),
        .grant_id_out         (rr_id),
        .stall_cnt_out        (rr_stall)
    );

    riscv32_wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_EN(1'b0), .CNT_W(3)) u_fp (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .req0_valid_in        (v0),
        .req0_rd_addr_in      (a0),
        .req0_data_in         (d0),
        .req0_ready_out       (fp_rdy0),
        .req1_valid_in        (v1),
        .req1_rd_addr_in      (a1),
        .req1_data_in         (d1),
        .req1_ready_out       (fp_rdy1),
        .wr_en_out            (fp_wr),
        .rd_addr_out          (fp_addr),
        .rd_out               (fp_data),
        .grant_id_out         (fp_id),
        .stall_cnt_out        (fp_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: index 0 = round-robin instance, index 1 = fixed-priority instance.
    bit          m_init = 1'b0;
    logic        m_wr   [2];
    logic [4:0]  m_addr [2];
    logic [31:0] m_data [2];
    logic        m_id   [2];
    int unsigned m_stall[2];
    logic        m_last [2];
    int unsigned m_max  [2] = '{65535, 7};

    // Returns -1 for no grant, otherwise the winning requester id.
    function automatic int model_grant(input int k);
        if (v0 && v1) begin
            if (k == 0) return (m_last[k] == 1'b0) ? 1 : 0;
            return 0;
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_wr[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0;
                m_id[k] = 1'b0; m_stall[k] = 0;  m_last[k] = 1'b1;
            end else begin
                g = model_grant(k);
                if (v0 && v1 && m_stall[k] < m_max[k]) m_stall[k]++;
                if (g < 0) begin
                    m_wr[k] = 1'b0;
                end else begin
                    m_addr[k] = (g == 1) ? a1 : a0;
                    m_data[k] = (g == 1) ? d1 : d0;
                    m_wr[k]   = (m_addr[k] != 5'd0);
                    m_id[k]   = (g == 1);
                    m_last[k] = (g == 1);
                end
            end
        end
        if (rst) m_init = 1'b1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("rr ready0", 64'(rr_rdy0), 64'(model_grant(0) == 0));
            check("rr ready1", 64'(rr_rdy1), 64'(model_grant(0) == 1));
            check("rr wr_en",  64'(rr_wr),   64'(m_wr[0]));
            check("rr addr",   64'(rr_addr), 64'(m_addr[0]));
            check("rr data",   64'(rr_data), 64'(m_data[0]));
            check("rr id",     64'(rr_id),   64'(m_id[0]));
            check("rr stall",  64'(rr_stall), 64'(m_stall[0]));
            check("fp ready0", 64'(fp_rdy0), 64'(model_grant(1) == 0));
            check("fp ready1", 64'(fp_rdy1), 64'(model_grant(1) == 1));
            check("fp wr_en",  64'(fp_wr),   64'(m_wr[1]));
            check("fp addr",   64'(fp_addr), 64'(m_addr[1]));
            check("fp data",   64'(fp_data), 64'(m_data[1]));
            check("fp id",     64'(fp_id),   64'(m_id[1]));
            check("fp stall",  64'(fp_stall), 64'(m_stall[1]));
        end
    end

    task automatic drive(input logic r, input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                         input logic iv1, input logic [4:0] ia1, input logic [31:0] id1);
        rst = r; v0 = iv0; a0 = ia0; d0 = id0; v1 = iv1; a1 = ia1; d1 = id1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check("reset wr_en", 64'(rr_wr), 64'd0);
        check("reset stall", 64'(rr_stall), 64'd0);
        check("reset id",    64'(fp_id), 64'd0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        do_reset();

        // Single req0 write.
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("A ready0", 64'(rr_rdy0), 64'd1);
        tick();
        check("A wr_en", 64'(rr_wr),   64'd1);
        check("A addr",  64'(rr_addr), 64'd5);
        check("A data",  64'(rr_data), 64'hDEADBEEF);
        check("A id",    64'(rr_id),   64'd0);

        // Continuous tie for 4 cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
            check("B rr ready0", 64'(rr_rdy0), 64'((i % 2) == 0));
            check("B rr ready1", 64'(rr_rdy1), 64'((i % 2) == 1));
            check("B fp ready0", 64'(fp_rdy0), 64'd1);
            check("B fp ready1", 64'(fp_rdy1), 64'd0);
            tick();
            check("B rr addr", 64'(rr_addr), ((i % 2) == 0) ? 64'd1 : 64'd2);
            check("B rr data", 64'(rr_data), ((i % 2) == 0) ? 64'h11 : 64'h22);
            check("B fp addr", 64'(fp_addr), 64'd1);
        end
        check("B rr stall", 64'(rr_stall), 64'd4);
        check("B fp stall", 64'(fp_stall), 64'd4);

        // Write to x0 handshakes but never enables the file.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        check("C ready1", 64'(rr_rdy1), 64'd1);
        tick();
        check("C wr_en", 64'(rr_wr),   64'd0);
        check("C data",  64'(rr_data), 64'hFFFFFFFF);
        check("C id",    64'(rr_id),   64'd1);

        // Same rd from both: req0 first, req1 next.
        do_reset();
        drive(1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
        tick();
        check("D1 wr_en", 64'(rr_wr), 64'd1);
        check("D1 data",  64'(rr_data), 64'hA);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB);
        tick();
        check("D2 wr_en", 64'(rr_wr), 64'd1);
        check("D2 data",  64'(rr_data), 64'hB);
        check("D2 id",    64'(rr_id), 64'd1);

        // Reset the cycle after a grant discards the pending write.
        drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        tick();
        check("E pre wr_en", 64'(rr_wr), 64'd1);
        drive(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        tick();
        check("E wr_en", 64'(rr_wr), 64'd0);
        check("E stall", 64'(rr_stall), 64'd0);
        drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        check("E tie ready0", 64'(rr_rdy0), 64'd1);
        check("E tie ready1", 64'(rr_rdy1), 64'd0);
        tick();
        check("E id", 64'(rr_id), 64'd0);

        // Long tie saturates the narrow counter.
        for (int i = 0; i < 10; i++) tick();
        check("F fp stall sat", 64'(fp_stall), 64'd7);
        check("F rr stall",     64'(rr_stall), 64'd11);

        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check("F idle wr_en", 64'(rr_wr), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
